// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 16-bit ALU issue path.
//   OP_W / OP_*   : opcode width and the eight legal ALU opcodes (0-7).
//   state_t       : issue FSM encoding (IDLE, EXEC, RESP).
//   op_class_t    : result of classify_op(): legal opcode / ADD-or-SUB.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_NAND = 4'd6;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic legal;   // opcode 0-7
    logic addsub;  // ADD or SUB: the only ops whose overflow is meaningful
  } op_class_t;

  function automatic op_class_t classify_op(input logic [OP_W-1:0] op);
    op_class_t c;
    c.legal  = (op <= OP_SLT);
    c.addsub = (op == OP_ADD) || (op == OP_SUB);
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// -----------------------------------------------------------------------------
// alu_issue_unit_if
// Request/response bus of the ALU issue unit plus its status/control lines.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1; the sender holds valid and its payload
// stable until that edge, and ready may be asserted independently of valid.
//   req_*        : request channel (producer -> unit)
//   rsp_*        : response channel (unit -> consumer)
//   clr_sticky   : synchronous clear of ovfl_sticky
//   ovfl_sticky  : sticky overflow status
//   op_count     : number of responses accepted (wraps)
// Modports: master = producer/consumer side, slave = the issue unit.
// -----------------------------------------------------------------------------
interface alu_issue_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  import alu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [OP_W-1:0]      req_op;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_result;
  logic                 rsp_zero;
  logic                 rsp_neg;
  logic                 rsp_ovfl;
  logic                 rsp_err;

  logic                 clr_sticky;
  logic                 ovfl_sticky;
  logic [CNT_W-1:0]     op_count;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, clr_sticky,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_ovfl,
           rsp_err, ovfl_sticky, op_count
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, clr_sticky,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_ovfl,
           rsp_err, ovfl_sticky, op_count
  );

endinterface

// File: rtl/alu16b.sv
// -----------------------------------------------------------------------------
// alu16b
// Combinational ALU.
//   a, b  : signed operands
//   op    : opcode (AND, OR, ADD, SUB, XOR, NOR, NAND, SLT); others give r=0
//   r     : result
//   ovfl  : signed overflow, valid for ADD/SUB only
// SLT returns the raw sign of a-b without overflow correction.
// -----------------------------------------------------------------------------
module alu16b
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] r,
  output logic             ovfl
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum  = a + b;
    diff = a - b;
    r    = '0;
    ovfl = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD: begin
        r    = sum;
        ovfl = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r    = diff;
        ovfl = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
// Valid/ready front end for alu16b. One operation in flight at a time:
// IDLE (accept request) -> EXEC (ALU evaluates registered operands, result
// captured at end of cycle) -> RESP (response held until accepted).
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : alu_issue_unit_if.slave (request, response, sticky, counter)
//   state  : current FSM state, for observation
// -----------------------------------------------------------------------------
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  alu_issue_unit_if.slave     bus,
  output state_t              state
);

  state_t           state_q, state_d;

  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovfl_q;
  logic             err_q;
  logic             sticky_q;
  logic [CNT_W-1:0] count_q;

  logic             req_ready_c;
  logic             rsp_valid_c;
  logic             capture;
  logic             req_fire;
  logic             rsp_fire;

  logic [WIDTH-1:0] alu_r;
  logic             alu_ovfl;
  op_class_t        cls;

  // FSM next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_fire = req_ready_c & bus.req_valid;
  assign rsp_fire = rsp_valid_c & bus.rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand registers: only loaded on an accepted request, so req_* is
  // ignored in EXEC and RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (req_fire) begin
      op_q <= bus.req_op;
      a_q  <= bus.req_a;
      b_q  <= bus.req_b;
    end
  end

  alu16b #(.WIDTH(WIDTH)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .r    (alu_r),
    .ovfl (alu_ovfl)
  );

  assign cls = classify_op(op_q);

  // Response capture at the end of EXEC. Illegal opcodes bypass the ALU
  // entirely; overflow is only taken from the ALU for ADD/SUB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovfl_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (capture) begin
      if (!cls.legal) begin
        result_q <= '0;
        zero_q   <= 1'b0;
        neg_q    <= 1'b0;
        ovfl_q   <= 1'b0;
        err_q    <= 1'b1;
      end else begin
        result_q <= alu_r;
        zero_q   <= (alu_r == '0);
        neg_q    <= alu_r[WIDTH-1];
        ovfl_q   <= cls.addsub & alu_ovfl;
        err_q    <= 1'b0;
      end
    end
  end

  // Sticky overflow: a set from an overflowing handshake beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    sticky_q <= 1'b0;
    else if (rsp_fire && ovfl_q)  sticky_q <= 1'b1;
    else if (bus.clr_sticky)      sticky_q <= 1'b0;
  end

  // Completed-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         count_q <= '0;
    else if (rsp_fire) count_q <= count_q + CNT_W'(1);
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_neg     = neg_q;
  assign bus.rsp_ovfl    = ovfl_q;
  assign bus.rsp_err     = err_q;
  assign bus.ovfl_sticky = sticky_q;
  assign bus.op_count    = count_q;
  assign state           = state_q;

endmodule
